// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter for two result producers.
//
// Each source (index 0 = ALU, index 1 = LSB) feeds a private FIFO of Q_DEPTH
// {rob_id, value} entries. Every live cycle at most one queue head is
// broadcast on the registered CDB outputs. When both queues hold entries,
// the grant goes to the source that did not win last time (round-robin).
//
// Ports
//   clk_in                       system clock, rising edge
//   rst_in                       asynchronous reset, active low
//   rdy_in                       global ready, low freezes the block
//   clear                        flush both queues (branch mispredict)
//   alu_valid/rob_id/value       ALU result offer
//   alu_ready                    ALU queue can accept this cycle
//   lsb_valid/rob_id/value       load result offer
//   lsb_ready                    LSB queue can accept this cycle
//   cdb_valid/rob_id/value/src   registered broadcast (src 0 = ALU, 1 = LSB)

// Per-source FIFO. Storage is not reset: only count and pointers define
// which slots are meaningful.
module cdb_fifo #(
    parameter int W       = 36,
    parameter int Q_DEPTH = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(Q_DEPTH):0] count
);
    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [Q_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign head = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

module cdb_arbiter #(
    parameter int ROB_WIDTH_BIT = 4,
    parameter int Q_DEPTH       = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic                     alu_valid,
    input  logic [ROB_WIDTH_BIT-1:0] alu_rob_id,
    input  logic [31:0]              alu_value,
    output logic                     alu_ready,
    input  logic                     lsb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_value,
    output logic                     lsb_ready,
    output logic                     cdb_valid,
    output logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
    output logic [31:0]              cdb_value,
    output logic                     cdb_src
);
    localparam int CW = $clog2(Q_DEPTH) + 1;

    typedef struct packed {
        logic [ROB_WIDTH_BIT-1:0] rob_id;
        logic [31:0]              value;
    } cdb_entry_t;

    localparam int EW = $bits(cdb_entry_t);

    cdb_entry_t [1:0]     q_din, q_head;
    logic [1:0][CW-1:0]   q_cnt;
    logic [1:0]           q_valid, q_ready, q_push, q_pop, q_busy;
    logic                 live, gnt_any, gnt_src, last_grant;

    assign live      = rdy_in && !clear;
    assign q_valid   = {lsb_valid, alu_valid};
    assign q_din[0]  = '{rob_id: alu_rob_id, value: alu_value};
    assign q_din[1]  = '{rob_id: lsb_rob_id, value: lsb_value};
    assign alu_ready = q_ready[0];
    assign lsb_ready = q_ready[1];

    generate
        for (genvar i = 0; i < 2; i++) begin : g_src
            assign q_busy[i]  = q_cnt[i] != '0;
            // Ready looks only at the current count: a same-cycle pop never
            // frees a slot early, keeping this path short.
            assign q_ready[i] = rst_in && live && (q_cnt[i] < CW'(Q_DEPTH));
            assign q_push[i]  = q_valid[i] && q_ready[i];
            assign q_pop[i]   = gnt_any && (gnt_src == 1'(i));

            cdb_fifo #(.W(EW), .Q_DEPTH(Q_DEPTH)) u_fifo (
                .clk_in (clk_in),
                .rst_in (rst_in),
                .flush  (clear),
                .push   (q_push[i]),
                .pop    (q_pop[i]),
                .din    (q_din[i]),
                .head   (q_head[i]),
                .count  (q_cnt[i])
            );
        end
    endgenerate

    // A lone candidate wins outright; on a tie the loser of last time wins.
    always_comb begin
        gnt_any = live && (|q_busy);
        gnt_src = (&q_busy) ? !last_grant : q_busy[1];
    end

    // last_grant resets to LSB so the very first tie goes to the ALU.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= 1'b0;
            last_grant <= 1'b1;
        end else if (clear) begin
            cdb_valid  <= 1'b0;
        end else if (rdy_in) begin
            cdb_valid <= gnt_any;
            if (gnt_any) begin
                cdb_rob_id <= q_head[gnt_src].rob_id;
                cdb_value  <= q_head[gnt_src].value;
                cdb_src    <= gnt_src;
                last_grant <= gnt_src;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    localparam int RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          clear  = 1'b0;
    logic          alu_valid = 1'b0;
    logic [RW-1:0] alu_rob_id = '0;
    logic [31:0]   alu_value = '0;
    logic          alu_ready;
    logic          lsb_valid = 1'b0;
    logic [RW-1:0] lsb_rob_id = '0;
    logic [31:0]   lsb_value = '0;
    logic          lsb_ready;
    logic          cdb_valid;
    logic [RW-1:0] cdb_rob_id;
    logic [31:0]   cdb_value;
    logic          cdb_src;

    cdb_arbiter #(.ROB_WIDTH_BIT(RW), .Q_DEPTH(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [RW-1:0] id;
        logic [31:0]   val;
    } exp_t;

    exp_t alu_q[$];
    exp_t lsb_q[$];
    logic src_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A broadcast is new only if the edge that produced it was live.
    logic live_q = 1'b0;
    always @(posedge clk_in) live_q <= rst_in && rdy_in && !clear;

    always @(negedge clk_in) begin : monitor
        exp_t e;
        logic s;
        if (live_q && cdb_valid) begin
            if (src_q.size() == 0) begin
                chk("unexpected_broadcast", {28'h0, cdb_rob_id}, 32'hFFFF_FFFF);
            end else begin
                s = src_q.pop_front();
                chk("cdb_src", 32'(cdb_src), 32'(s));
                if (s == 1'b0 && alu_q.size() == 0)
                    chk("alu_entry_missing", 32'(cdb_rob_id), 32'hFFFF_FFFF);
                else if (s == 1'b1 && lsb_q.size() == 0)
                    chk("lsb_entry_missing", 32'(cdb_rob_id), 32'hFFFF_FFFF);
                else begin
                    e = (s == 1'b0) ? alu_q.pop_front() : lsb_q.pop_front();
                    chk("cdb_rob_id", 32'(cdb_rob_id), 32'(e.id));
                    chk("cdb_value", cdb_value, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
        clear     = 1'b0;
        rdy_in    = 1'b1;
    endtask

    // Applies one vector; ar/lr are the hand-computed ready values, and an
    // offer is expected to be accepted exactly when valid && expected ready.
    task automatic drive(input logic av, input logic [RW-1:0] aid, input logic [31:0] aval, input logic ar,
                         input logic lv, input logic [RW-1:0] lid, input logic [31:0] lval, input logic lr);
        alu_valid = av; alu_rob_id = aid; alu_value = aval;
        lsb_valid = lv; lsb_rob_id = lid; lsb_value = lval;
        #1;
        chk("alu_ready", 32'(alu_ready), 32'(ar));
        chk("lsb_ready", 32'(lsb_ready), 32'(lr));
        if (av && ar) alu_q.push_back('{aid, aval});
        if (lv && lr) lsb_q.push_back('{lid, lval});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic ar_t [7];
        logic lr_t [7];
        logic fill_src [9];
        ar_t = '{1, 1, 1, 0, 1, 0, 1};
        lr_t = '{1, 1, 0, 1, 0, 1, 0};
        fill_src = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

        // Reset state, with rdy_in high so ready is gated by reset alone.
        #2;
        chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("rst_cdb_rob_id", 32'(cdb_rob_id), 32'h0);
        chk("rst_cdb_value", cdb_value, 32'h0);
        chk("rst_cdb_src", 32'(cdb_src), 32'h0);
        chk("rst_alu_ready", 32'(alu_ready), 32'h0);
        chk("rst_lsb_ready", 32'(lsb_ready), 32'h0);
        tick(); tick();
        rst_in = 1'b1;

        // Single ALU push: visible after the second edge, gone after the third.
        src_q.push_back(1'b0);
        drive(1, 4'd3, 32'h1234_5678, 1, 0, 4'd0, 32'h0, 1);
        tick(); idle();
        chk("no_bypass_valid", 32'(cdb_valid), 32'h0);
        tick();
        chk("single_valid", 32'(cdb_valid), 32'h1);
        tick();
        chk("single_valid_drop", 32'(cdb_valid), 32'h0);

        // Queue entries in both sources, then reset mid-operation: they must vanish.
        alu_valid = 1'b1; alu_rob_id = 4'd5; alu_value = 32'h5555_5555;
        lsb_valid = 1'b1; lsb_rob_id = 4'd6; lsb_value = 32'h6666_6666;
        tick();
        rst_in = 1'b0; idle();
        #1;
        chk("midrst_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("midrst_alu_ready", 32'(alu_ready), 32'h0);
        tick(); tick();
        rst_in = 1'b1;

        // Simultaneous first pushes after reset: ALU wins the first tie.
        src_q.push_back(1'b0); src_q.push_back(1'b1);
        drive(1, 4'd1, 32'h0000_00A1, 1, 1, 4'd2, 32'h0000_00B2, 1);
        tick(); idle();
        tick(); tick(); tick();

        // Both sources offer every cycle: queues fill, readies drop at count 2,
        // and grants alternate strictly.
        foreach (fill_src[i]) src_q.push_back(fill_src[i]);
        for (int k = 1; k <= 7; k++) begin
            drive(1, 4'(k), 32'hA000_0000 | k, ar_t[k-1],
                  1, 4'(8 + k), 32'hB000_0000 | k, lr_t[k-1]);
            tick();
        end
        idle();
        tick(); tick(); tick(); tick();

        // Two entries queued, then clear together with a new ALU offer.
        alu_valid = 1'b1; alu_rob_id = 4'hC; alu_value = 32'hC0C0_C0C0;
        lsb_valid = 1'b1; lsb_rob_id = 4'hD; lsb_value = 32'hD0D0_D0D0;
        tick();
        clear = 1'b1; lsb_valid = 1'b0;
        alu_valid = 1'b1; alu_rob_id = 4'd7; alu_value = 32'h0000_0777;
        #1;
        chk("clear_alu_ready", 32'(alu_ready), 32'h0);
        chk("clear_lsb_ready", 32'(lsb_ready), 32'h0);
        tick(); idle();
        chk("clear_cdb_valid", 32'(cdb_valid), 32'h0);
        // last_grant was ALU before clear and must be held: LSB wins this tie.
        src_q.push_back(1'b1); src_q.push_back(1'b0);
        drive(1, 4'h9, 32'h9999_0009, 1, 1, 4'hA, 32'hAAAA_000A, 1);
        tick(); idle();
        tick(); tick(); tick();

        // Pause with a valid broadcast and entries pending.
        src_q.push_back(1'b1); src_q.push_back(1'b0);
        src_q.push_back(1'b1); src_q.push_back(1'b0);
        drive(1, 4'h1, 32'h1111_0001, 1, 1, 4'h2, 32'h2222_0002, 1);
        tick();
        drive(1, 4'h3, 32'h1111_0003, 1, 1, 4'h4, 32'h2222_0004, 1);
        tick();
        rdy_in = 1'b0;
        drive(1, 4'hE, 32'hEEEE_EEEE, 0, 1, 4'hF, 32'hFFFF_FFFF, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frozen_valid", 32'(cdb_valid), 32'h1);
            chk("frozen_src", 32'(cdb_src), 32'h1);
            chk("frozen_rob_id", 32'(cdb_rob_id), 32'h2);
            chk("frozen_value", cdb_value, 32'h2222_0002);
        end
        idle();
        tick(); tick(); tick(); tick(); tick();

        #1;
        chk("src_q_drained", src_q.size(), 32'h0);
        chk("alu_q_drained", alu_q.size(), 32'h0);
        chk("lsb_q_drained", lsb_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
